nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  - Multi-cycle WIDTH-bit adder built around one CLA4 slice (4-bit carry-lookahead adder).
//  - Adds one nibble per clock, least significant nibble first, and registers the carry between slices.
//  - Sits directly downstream of CLA4: it consumes CLA4's S/Cout every cycle and assembles the wide result.
//  - Valid/ready handshakes on both sides, so it drops into the arithmetic datapath between the operand source and the result consumer.
// PARAMETERS
//  - WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8.
//  - NIB    WIDTH/4 (localparam)  number of RUN cycles per operation.
// PORTS
//  - CLK        in   1      rising-edge clock
//  - RST        in   1      asynchronous, active-high reset
//  - IN_VALID   in   1      operands A/B/CIN valid this cycle
//  - IN_READY   out  1      block can accept operands (high only in IDLE)
//  - A          in   WIDTH  addend A
//  - B          in   WIDTH  addend B
//  - CIN        in   1      carry into bit 0
//  - OUT_VALID  out  1      S/COUT/OVF valid; held until OUT_READY
//  - OUT_READY  in   1      consumer takes the result
//  - S          out  WIDTH  sum A+B+CIN mod 2^WIDTH
//  - COUT       out  1      carry out of bit WIDTH-1
//  - OVF        out  1      two's-complement overflow: (A[msb]==B[msb]) && (S[msb]!=A[msb])
// BEHAVIOUR
//  - Reset (async, while RST=1): state=IDLE, IN_READY=1, OUT_VALID=0, S=0, COUT=0, OVF=0.
//  - Reset also clears the operand shift registers, the carry register and the slice counter.
//  - Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and nothing is emitted.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE:
//    - IN_READY=1.
//    - On the edge with IN_VALID=1: capture A and B into shift registers, CIN into the carry register, cnt=0, then go to RUN.
//    - IN_VALID=0: stay in IDLE.
//  - RUN:
//    - IN_READY=0. IN_VALID is ignored and the A/B/CIN inputs are don't-care.
//    - Each cycle, CLA4 adds a_sh[3:0] + b_sh[3:0] + carry.
//    - On the edge:
//      - S shifts right by 4, with the CLA4 sum nibble entering at S[WIDTH-1:WIDTH-4].
//      - carry <= CLA4 Cout; a_sh and b_sh shift right by 4; cnt++.
//    - When cnt==NIB-1 on that edge:
//      - COUT <= CLA4 Cout.
//      - OVF computed from the current slice MSBs (a_sh[3], b_sh[3], sum[3]).
//      - Go to DONE.
//  - DONE:
//    - OUT_VALID=1; S, COUT and OVF are held stable.
//    - On the edge with OUT_READY=1: go to IDLE, OUT_VALID drops the next cycle.
//    - OUT_READY=0: hold indefinitely.
//    - S/COUT/OVF keep their last values in IDLE and are not cleared.
//  - Latency:
//    - Operands accepted on edge T0; OUT_VALID is high after edge T0+NIB (4 cycles at WIDTH=16).
//    - Minimum issue interval is NIB+2 cycles.
//    - No accept in the same cycle as result handoff (IN_READY=0 in DONE).
//  - Arithmetic: unsigned modulo 2^WIDTH; COUT and OVF are always both produced.
//  - OUT_VALID, IN_READY, S, COUT and OVF are all driven from registers (no combinational input-to-output path).
// STRUCTURE
//  - Shared include cla_defs.vh:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; NIB_W=4.
//    - used by this block and its bench.
//  - One sub-module: the existing CLA4 (A, B, Cin, S, Cout), instantiated once as the slice adder.
//  - Counter width: $clog2(NIB), minimum 1 bit.
// TESTING (WIDTH=16; check each result at the OUT_VALID handshake)
//  1. A=16'h1234, B=16'h0F0F, CIN=0 -> S=16'h2143, COUT=0, OVF=0; OUT_VALID exactly 4 cycles after the accept edge.
//  2. A=16'hFFFF, B=16'h0001, CIN=0 -> S=16'h0000, COUT=1, OVF=0 (carry ripples through all 4 slices).
//  3. A=16'h7FFF, B=16'h0001, CIN=0 -> S=16'h8000, COUT=0, OVF=1.
//     A=16'h8000, B=16'h8000 -> S=0, COUT=1, OVF=1.
//  4. Back-pressure on A=16'h0000, B=16'h0000, CIN=1 -> S=16'h0001:
//     - hold OUT_READY=0 for 3 cycles -> OUT_VALID, S and COUT stay stable.
//     - IN_READY stays 0; IN_VALID pulses with new operands are ignored.
//  5. Assert RST during the 2nd RUN cycle -> S/COUT/OVF/OUT_VALID are 0 immediately, IN_READY=1.
//     After release, A=16'h00FF, B=16'h0001 -> S=16'h0100.
//  6. Back-to-back: IN_VALID held high with OUT_READY tied 1 -> next accept occurs on the first IDLE cycle.
//     Three random operand pairs all match the A+B+CIN golden model.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice geometry.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-slice operation still needs a one-bit counter.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead slice: all internal carries are formed from generate/propagate terms.
module nibble_serial_adder_cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g, p;
    logic [4:0] c;

    assign g    = A & B;
    assign p    = A ^ B;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA4 slice consumes a nibble per clock, LSB nibble first,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = cnt_width(NIB);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [3:0]       sl_sum;
    logic             sl_cout;

    nibble_serial_adder_cla4 u_cla4 (
        .A   (a_q[3:0]),
        .B   (b_q[3:0]),
        .Cin (carry_q),
        .S   (sl_sum),
        .Cout(sl_cout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum nibbles enter at the top so the first one lands at bit 0 after NIB shifts.
                s_d     = {sl_sum, s_q[WIDTH-1:NIB_W]};
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                carry_d = sl_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[3] == b_q[3]) && (sl_sum[3] != a_q[3]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign S         = s_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes expected results, monitor checks
// each result at the OUT_VALID/OUT_READY handshake along with accept-to-valid latency.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / NIB_W;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } res_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             CIN = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] S;
    logic             COUT;
    logic             OVF;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .S(S), .COUT(COUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    int   acc_q[$];
    logic prev_ov = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        res_t r;
        int   u;
        int   si;
        u   = int'(a) + int'(b) + int'(c);
        si  = int'($signed(a)) + int'($signed(b)) + int'(c);
        r.s = u[WIDTH-1:0];
        r.c = u[WIDTH];
        r.o = (si > 32767) || (si < -32768);
        return r;
    endfunction

    always @(negedge CLK) begin
        res_t e;
        int   a0;
        if (RST) begin
            prev_ov = 1'b0;
        end else begin
            if (OUT_VALID && !prev_ov) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 32'(OUT_VALID), 32'(0));
                else begin
                    a0 = acc_q.pop_front();
                    chk("latency", 32'(cyc - a0), 32'(NIB));
                end
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) chk("unexpected_output", 32'(OUT_VALID), 32'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("S", 32'(S), 32'(e.s));
                    chk("COUT", 32'(COUT), 32'(e.c));
                    chk("OVF", 32'(OVF), 32'(e.o));
                end
            end
            prev_ov = OUT_VALID;
        end
    end

    task automatic send_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                            input res_t e, output int acc);
        int g = 0;
        acc = -1;
        @(negedge CLK);
        A = a; B = b; CIN = c; IN_VALID = 1'b1;
        while (!IN_READY && g < 100) begin
            @(negedge CLK);
            g++;
        end
        if (!IN_READY) chk("accept_timeout", 32'(IN_READY), 32'(1));
        else begin
            exp_q.push_back(e);
            acc = cyc + 1;
            acc_q.push_back(acc);
        end
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int acc;
        send_exp(a, b, c, model(a, b, c), acc);
    endtask

    task automatic drain();
        int g = 0;
        OUT_READY = 1'b1;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        @(negedge CLK);
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   prev_acc;
        int   g;
        int   n;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        #12;
        chk("rst_in_ready", 32'(IN_READY), 32'(1));
        chk("rst_out_valid", 32'(OUT_VALID), 32'(0));
        chk("rst_s", 32'(S), 32'(0));
        chk("rst_cout_ovf", 32'({COUT, OVF}), 32'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        OUT_READY = 1'b1;
        send_exp(16'h1234, 16'h0F0F, 1'b0, '{16'h2143, 1'b0, 1'b0}, acc);
        drain();
        send_exp(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, acc);
        drain();
        send_exp(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, acc);
        drain();
        send_exp(16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}, acc);
        drain();

        // Back-pressure: result must hold and new operands must be refused.
        OUT_READY = 1'b0;
        send_exp(16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}, acc);
        g = 0;
        while (!OUT_VALID && g < 50) begin
            @(negedge CLK);
            g++;
        end
        for (int k = 0; k < 3; k++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom); IN_VALID = 1'b1;
            chk("bp_out_valid", 32'(OUT_VALID), 32'(1));
            chk("bp_s", 32'(S), 32'(16'h0001));
            chk("bp_cout", 32'(COUT), 32'(0));
            chk("bp_in_ready", 32'(IN_READY), 32'(0));
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        drain();

        // Leave nonzero S/COUT/OVF behind so the reset clear is visible.
        send_exp(16'hFFFF, 16'h8000, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, acc);
        drain();
        send(16'h1234, 16'h0F0F, 1'b0);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("abort_out_valid", 32'(OUT_VALID), 32'(0));
        chk("abort_in_ready", 32'(IN_READY), 32'(1));
        chk("abort_s", 32'(S), 32'(0));
        chk("abort_cout_ovf", 32'({COUT, OVF}), 32'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        send_exp(16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0}, acc);
        drain();

        // Back-to-back with IN_VALID held: accepts every NIB+2 cycles.
        OUT_READY = 1'b1;
        n = 0;
        g = 0;
        prev_acc = -1;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
        @(negedge CLK);
        A = ra; B = rb; CIN = rc; IN_VALID = 1'b1;
        while (n < 3 && g < 200) begin
            if (IN_READY) begin
                exp_q.push_back(model(ra, rb, rc));
                acc = cyc + 1;
                acc_q.push_back(acc);
                if (prev_acc >= 0) chk("issue_interval", 32'(acc - prev_acc), 32'(NIB + 2));
                prev_acc = acc;
                n++;
                @(posedge CLK);
                #1;
                ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
                A = ra; B = rb; CIN = rc;
            end
            @(negedge CLK);
            g++;
        end
        IN_VALID = 1'b0;
        chk("b2b_count", 32'(n), 32'(3));
        drain();

        for (int k = 0; k < 12; k++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            OUT_READY = 1'b0;
            repeat ($urandom_range(NIB, NIB + 4)) @(negedge CLK);
            drain();
        end

        repeat (20) @(negedge CLK);
        chk("final_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
